// File: rtl/auto_req_initiator.sv
// auto_req_initiator: credit-based request issuer with a buffered, credit-returning response FIFO
module auto_req_initiator #(
  parameter int REQ_CREDITS = 4,
  parameter int RSP_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        host_req_valid,
  input  logic [63:0] host_req_data,
  output logic        host_req_ready,
  output logic        req_val,
  output logic [63:0] req_data,
  input  logic        req_credit,
  input  logic [1:0]  rsp_cmd,
  input  logic [63:0] rsp_data,
  output logic        rsp_credit,
  output logic        host_rsp_valid,
  input  logic        host_rsp_ready,
  output logic [1:0]  host_rsp_cmd,
  output logic [63:0] host_rsp_data,
  output logic        credit_err,
  output logic        rsp_ovf
);
  localparam int AW = $clog2(RSP_DEPTH);
  logic [3:0] credits;
  logic [65:0] mem [RSP_DEPTH];
  logic [AW:0] wr_ptr, rd_ptr;
  logic send, empty, full, pop, push;
  assign host_req_ready = credits != 4'd0;
  assign send = host_req_valid && host_req_ready;
  assign empty = wr_ptr == rd_ptr;
  assign full = (wr_ptr ^ rd_ptr) == {1'b1, {AW{1'b0}}};
  assign pop = !empty && host_rsp_ready;
  assign push = (rsp_cmd != 2'b00) && (!full || pop);
  assign host_rsp_valid = !empty;
  assign {host_rsp_cmd, host_rsp_data} = empty ? 66'd0 : mem[rd_ptr[AW-1:0]];
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      credits <= 4'(REQ_CREDITS);
      req_val <= 1'b0;
      req_data <= '0;
      rsp_credit <= 1'b0;
      credit_err <= 1'b0;
      rsp_ovf <= 1'b0;
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      req_val <= send;
      if (send) req_data <= host_req_data;
      if (send && !req_credit) credits <= credits - 4'd1;
      else if (!send && req_credit) begin
        if (credits == 4'(REQ_CREDITS)) credit_err <= 1'b1;
        else credits <= credits + 4'd1;
      end
      rsp_credit <= pop;
      if (push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (pop) rd_ptr <= rd_ptr + (AW+1)'(1);
      if ((rsp_cmd != 2'b00) && full && !pop) rsp_ovf <= 1'b1;
    end
  end
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= {rsp_cmd, rsp_data};
  end
endmodule

// File: tb/tb_auto_req_initiator.sv
// tb_auto_req_initiator: directed scenario tests for auto_req_initiator
module tb_auto_req_initiator;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        host_req_valid = 1'b0;
  logic [63:0] host_req_data = '0;
  logic        host_req_ready;
  logic        req_val;
  logic [63:0] req_data;
  logic        req_credit = 1'b0;
  logic [1:0]  rsp_cmd = 2'b00;
  logic [63:0] rsp_data = '0;
  logic        rsp_credit;
  logic        host_rsp_valid;
  logic        host_rsp_ready = 1'b0;
  logic [1:0]  host_rsp_cmd;
  logic [63:0] host_rsp_data;
  logic        credit_err;
  logic        rsp_ovf;
  int vectors = 0;
  int miscompares = 0;
  always #5 clk = ~clk;
  auto_req_initiator dut (
    .clk(clk), .rst(rst),
    .host_req_valid(host_req_valid), .host_req_data(host_req_data), .host_req_ready(host_req_ready),
    .req_val(req_val), .req_data(req_data), .req_credit(req_credit),
    .rsp_cmd(rsp_cmd), .rsp_data(rsp_data), .rsp_credit(rsp_credit),
    .host_rsp_valid(host_rsp_valid), .host_rsp_ready(host_rsp_ready),
    .host_rsp_cmd(host_rsp_cmd), .host_rsp_data(host_rsp_data),
    .credit_err(credit_err), .rsp_ovf(rsp_ovf)
  );
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic test_reset;
    repeat (2) @(posedge clk);
    #1;
    vectors++; if (req_val !== 1'b0) begin miscompares++; $display("FAIL reset_req_val got %b want 0", req_val); end
    vectors++; if (req_data !== 64'd0) begin miscompares++; $display("FAIL reset_req_data got %h want 0", req_data); end
    vectors++; if (rsp_credit !== 1'b0) begin miscompares++; $display("FAIL reset_rsp_credit got %b want 0", rsp_credit); end
    vectors++; if (host_rsp_valid !== 1'b0) begin miscompares++; $display("FAIL reset_rsp_valid got %b want 0", host_rsp_valid); end
    vectors++; if ({host_rsp_cmd, host_rsp_data} !== 66'd0) begin miscompares++; $display("FAIL reset_rsp_head got %h want 0", {host_rsp_cmd, host_rsp_data}); end
    vectors++; if ({credit_err, rsp_ovf} !== 2'b00) begin miscompares++; $display("FAIL reset_flags got %b want 00", {credit_err, rsp_ovf}); end
    vectors++; if (host_req_ready !== 1'b1) begin miscompares++; $display("FAIL reset_req_ready got %b want 1", host_req_ready); end
    vectors++; if (dut.credits !== 4'd4) begin miscompares++; $display("FAIL reset_credits got %0d want 4", dut.credits); end
    rst = 1'b0;
  endtask
  task automatic test_credit_exhaust;
    host_req_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      host_req_data = 64'd100 + 64'(i);
      tick();
      vectors++; if (req_val !== (i < 4)) begin miscompares++; $display("FAIL exhaust_req_val[%0d] got %b want %b", i, req_val, i < 4); end
      vectors++; if (req_data !== 64'd100 + 64'(i < 4 ? i : 3)) begin miscompares++; $display("FAIL exhaust_req_data[%0d] got %0d want %0d", i, req_data, 100 + (i < 4 ? i : 3)); end
    end
    vectors++; if (host_req_ready !== 1'b0) begin miscompares++; $display("FAIL exhaust_ready got %b want 0", host_req_ready); end
    req_credit = 1'b1;
    host_req_data = 64'd200;
    tick();
    vectors++; if ({req_val, host_req_ready} !== 2'b01) begin miscompares++; $display("FAIL refill_state got %b want 01", {req_val, host_req_ready}); end
    req_credit = 1'b0;
    host_req_data = 64'd201;
    tick();
    vectors++; if ({req_val, host_req_ready} !== 2'b10) begin miscompares++; $display("FAIL refill_beat got %b want 10", {req_val, host_req_ready}); end
    vectors++; if (req_data !== 64'd201) begin miscompares++; $display("FAIL refill_data got %0d want 201", req_data); end
    tick();
    vectors++; if (req_val !== 1'b0) begin miscompares++; $display("FAIL refill_single got %b want 0", req_val); end
    host_req_valid = 1'b0;
  endtask
  task automatic test_simul_send_credit;
    req_credit = 1'b1;
    tick();
    host_req_valid = 1'b1;
    host_req_data = 64'h55;
    tick();
    req_credit = 1'b0;
    host_req_valid = 1'b0;
    vectors++; if (dut.credits !== 4'd1) begin miscompares++; $display("FAIL simul_credits got %0d want 1", dut.credits); end
    vectors++; if ({req_val, host_req_ready} !== 2'b11) begin miscompares++; $display("FAIL simul_state got %b want 11", {req_val, host_req_ready}); end
  endtask
  task automatic test_credit_overflow;
    req_credit = 1'b1;
    repeat (3) tick();
    req_credit = 1'b0;
    vectors++; if ({dut.credits, credit_err} !== {4'd4, 1'b0}) begin miscompares++; $display("FAIL ovf_pre got %h want 8", {dut.credits, credit_err}); end
    req_credit = 1'b1;
    tick();
    req_credit = 1'b0;
    tick();
    vectors++; if ({dut.credits, credit_err} !== {4'd4, 1'b1}) begin miscompares++; $display("FAIL ovf_post got %h want 9", {dut.credits, credit_err}); end
  endtask
  task automatic test_fill;
    for (int i = 1; i <= 4; i++) begin
      rsp_cmd = 2'b01;
      rsp_data = 64'(i);
      tick();
      vectors++; if ({host_rsp_valid, host_rsp_cmd, host_rsp_data} !== {1'b1, 2'b01, 64'd1}) begin miscompares++; $display("FAIL fill_head[%0d] got %h want 1", i, {host_rsp_valid, host_rsp_cmd, host_rsp_data}); end
    end
    vectors++; if (rsp_ovf !== 1'b0) begin miscompares++; $display("FAIL fill_no_ovf got %b want 0", rsp_ovf); end
    rsp_data = 64'd5;
    tick();
    rsp_cmd = 2'b00;
    vectors++; if ({rsp_ovf, rsp_credit} !== 2'b10) begin miscompares++; $display("FAIL fill_ovf got %b want 10", {rsp_ovf, rsp_credit}); end
  endtask
  task automatic test_drain;
    host_rsp_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      vectors++; if (host_rsp_data !== 64'(i + 1)) begin miscompares++; $display("FAIL drain_data[%0d] got %0d want %0d", i, host_rsp_data, i + 1); end
      vectors++; if (rsp_credit !== (i > 0)) begin miscompares++; $display("FAIL drain_credit[%0d] got %b want %b", i, rsp_credit, i > 0); end
      tick();
    end
    host_rsp_ready = 1'b0;
    vectors++; if ({rsp_credit, host_rsp_valid} !== 2'b10) begin miscompares++; $display("FAIL drain_last got %b want 10", {rsp_credit, host_rsp_valid}); end
    tick();
    vectors++; if ({rsp_credit, host_rsp_valid} !== 2'b00) begin miscompares++; $display("FAIL drain_done got %b want 00", {rsp_credit, host_rsp_valid}); end
  endtask
  task automatic test_full_rw;
    rsp_cmd = 2'b01;
    for (int i = 0; i < 4; i++) begin
      rsp_data = 64'h11 + 64'(i);
      tick();
    end
    rsp_cmd = 2'b10;
    rsp_data = 64'h15;
    host_rsp_ready = 1'b1;
    tick();
    rsp_cmd = 2'b00;
    for (int i = 0; i < 4; i++) begin
      vectors++; if ({host_rsp_valid, host_rsp_cmd, host_rsp_data} !== {1'b1, (i == 3) ? 2'b10 : 2'b01, 64'h12 + 64'(i)}) begin miscompares++; $display("FAIL fullrw_head[%0d] got %h want %h", i, {host_rsp_valid, host_rsp_cmd, host_rsp_data}, {1'b1, (i == 3) ? 2'b10 : 2'b01, 64'h12 + 64'(i)}); end
      tick();
    end
    host_rsp_ready = 1'b0;
    vectors++; if (host_rsp_valid !== 1'b0) begin miscompares++; $display("FAIL fullrw_empty got %b want 0", host_rsp_valid); end
    tick();
  endtask
  task automatic test_reset_mid;
    host_req_valid = 1'b1;
    repeat (3) tick();
    host_req_valid = 1'b0;
    rsp_cmd = 2'b01;
    for (int i = 0; i < 3; i++) begin
      rsp_data = 64'h21 + 64'(i);
      tick();
    end
    rsp_cmd = 2'b00;
    vectors++; if ({dut.credits, host_rsp_valid} !== {4'd1, 1'b1}) begin miscompares++; $display("FAIL mid_pre got %h want 3", {dut.credits, host_rsp_valid}); end
    host_rsp_ready = 1'b1;
    #2 rst = 1'b1;
    #1;
    vectors++; if ({host_rsp_valid, rsp_credit, host_req_ready} !== 3'b001) begin miscompares++; $display("FAIL mid_async got %b want 001", {host_rsp_valid, rsp_credit, host_req_ready}); end
    vectors++; if (dut.credits !== 4'd4) begin miscompares++; $display("FAIL mid_credits got %0d want 4", dut.credits); end
    vectors++; if ({credit_err, rsp_ovf} !== 2'b00) begin miscompares++; $display("FAIL mid_flags got %b want 00", {credit_err, rsp_ovf}); end
    tick();
    rst = 1'b0;
    vectors++; if (rsp_credit !== 1'b0) begin miscompares++; $display("FAIL mid_hold_credit got %b want 0", rsp_credit); end
    tick();
    host_rsp_ready = 1'b0;
    vectors++; if ({host_rsp_valid, rsp_credit, host_req_ready} !== 3'b001) begin miscompares++; $display("FAIL mid_after got %b want 001", {host_rsp_valid, rsp_credit, host_req_ready}); end
  endtask
  initial begin
    test_reset();
    test_credit_exhaust();
    test_simul_send_credit();
    test_credit_overflow();
    test_fill();
    test_drain();
    test_full_rw();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/auto_req_initiator.md
AUTO_REQ_INITIATOR -- requirements
Module: auto_req_initiator

Interface
REQ-001 The block SHALL have parameter REQ_CREDITS, default 4, meaning initial request credits granted by the responder (1..15).
REQ-002 The block SHALL have parameter RSP_DEPTH, default 4, meaning response buffer entries, which also equals the responder's initial response credits (power of 2, 2..16).
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all logic is rising-edge.
REQ-004 The block SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-005 The block SHALL have port host_req_valid, input, 1 bit: host request offered.
REQ-006 The block SHALL have port host_req_data, input, 64 bits: host request payload.
REQ-007 The block SHALL have port host_req_ready, output, 1 bit: request accepted this cycle when valid is also high.
REQ-008 The block SHALL have port req_val, output, 1 bit: request beat valid toward the responder.
REQ-009 The block SHALL have port req_data, output, 64 bits: request beat payload.
REQ-010 The block SHALL have port req_credit, input, 1 bit: one-cycle pulse returning one request credit.
REQ-011 The block SHALL have port rsp_cmd, input, 2 bits: response command; 2'b00 = idle, nonzero = valid beat.
REQ-012 The block SHALL have port rsp_data, input, 64 bits: response payload, sampled when rsp_cmd != 0.
REQ-013 The block SHALL have port rsp_credit, output, 1 bit: one-cycle pulse returning one response credit.
REQ-014 The block SHALL have port host_rsp_valid, output, 1 bit: buffered response available.
REQ-015 The block SHALL have port host_rsp_ready, input, 1 bit: host pops the head response.
REQ-016 The block SHALL have ports host_rsp_cmd, output, 2 bits, and host_rsp_data, output, 64 bits: the head response.
REQ-017 The block SHALL have port credit_err, output, 1 bit: sticky flag for a request-credit overflow.
REQ-018 The block SHALL have port rsp_ovf, output, 1 bit: sticky flag for a response arriving while the buffer is full.

Function
REQ-019 The request credit counter (4 bits) SHALL load REQ_CREDITS on reset.
REQ-020 host_req_ready SHALL equal (credit counter != 0) and SHALL be driven from registers only, with no combinational path from host_req_valid.
REQ-021 On a host handshake in cycle N, req_val SHALL be 1 and req_data SHALL equal host_req_data in cycle N+1 only; otherwise req_val SHALL be 0 and req_data SHALL hold its last value.
REQ-022 The credit counter SHALL update per cycle as follows:
- send only: decrement by 1;
- req_credit only: increment by 1;
- both together: unchanged.
REQ-023 A req_credit arriving while the counter equals REQ_CREDITS and no send is occurring SHALL leave the counter saturated and SHALL set credit_err.
REQ-024 The response buffer SHALL be a FIFO of RSP_DEPTH entries, each holding {cmd, data}.
REQ-025 Each cycle with rsp_cmd != 0 SHALL write one entry.
REQ-026 A written entry SHALL be visible on host_rsp_valid/cmd/data in the following cycle (1-cycle latency when the buffer was empty).
REQ-027 host_rsp_valid SHALL be 1 whenever the FIFO is non-empty; host_rsp_cmd/data SHALL show the head entry.
REQ-028 A pop SHALL occur when host_rsp_valid and host_rsp_ready are both 1.
REQ-029 A write and a pop in the same cycle SHALL both take effect, leaving occupancy unchanged; this includes the full case.
REQ-030 A write while the FIFO is full with no simultaneous pop SHALL drop the beat and set rsp_ovf.
REQ-031 Each pop in cycle N SHALL produce rsp_credit = 1 in cycle N+1 (registered), one pulse per pop; back-to-back pops SHALL give back-to-back pulses.
REQ-032 FIFO read and write pointers SHALL wrap modulo RSP_DEPTH, with one extra bit to distinguish full from empty.
REQ-033 credit_err and rsp_ovf SHALL clear only on reset.

Reset
REQ-034 While rst=1, outputs SHALL be as follows:
- req_val=0, req_data=0, rsp_credit=0;
- host_rsp_valid=0, host_rsp_cmd=0, host_rsp_data=0;
- credit_err=0, rsp_ovf=0;
- credit counter=REQ_CREDITS, FIFO empty.
REQ-035 host_req_ready SHALL be 1 during reset when REQ_CREDITS > 0.
REQ-036 Reset asserted mid-transfer SHALL discard buffered responses and SHALL restore credits immediately, with no rsp_credit pulse issued for discarded entries.
REQ-037 The first handshake SHALL be possible on the first rising edge after rst deasserts.

Verification
REQ-038 Credit exhaustion: host_req_valid held 1 and no req_credit -> exactly 4 req_val beats, then host_req_ready=0; one req_credit pulse -> exactly one further beat.
REQ-039 Simultaneous send and credit: counter=1, host send and req_credit in the same cycle -> counter stays 1 and host_req_ready remains 1.
REQ-040 Response fill: 4 beats of rsp_cmd=2'b01, data 0x1..0x4, host_rsp_ready=0 -> FIFO full; a 5th beat -> rsp_ovf=1 and data 0x5 is never delivered.
REQ-041 Drain: host_rsp_ready=1 for 4 cycles -> data 0x1..0x4 delivered in order, 4 consecutive rsp_credit pulses each lagging its pop by 1 cycle.
REQ-042 Credit overflow: req_credit pulse with counter=4 and no send -> credit_err=1 and counter stays 4.
REQ-043 Reset mid-operation: rst pulse with 3 entries buffered and counter=1 -> host_rsp_valid=0, counter=4, no rsp_credit pulse.
